if_prefetch_stage: RTL

- Instruction-fetch stage that feeds the IF/ID pipeline register.
- Drives the instruction-memory address (synchronous read, 1-cycle latency) and tags each returned word with its PC.
- Buffers fetched words in a small prefetch queue so that decode stalls do not lose in-flight fetches.
- On a taken branch from the RF stage, flushes the queue and any in-flight fetch, then redirects to the branch target.

---
 rtl/if_prefetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - instruction fetch stage with prefetch queue and branch redirect
//
// Fetches instructions from a synchronous-read instruction memory (1-cycle
// latency). Each returned word is tagged with its PC and buffered in a
// DEPTH-entry queue, so a decode stall never drops an in-flight fetch. A
// taken branch from the RF stage flushes the queue and the in-flight fetch,
// and fetching restarts at the branch target.
//
// Ports:
//   HCLK                in   system clock
//   HRESETn             in   synchronous active-low reset
//   Imem2proc_data      in   memory word for the address issued last cycle
//   rf_take_branch_out  in   redirect request
//   rf_target_PC_out    in   redirect target (bits [1:0] ignored)
//   id_ready            in   consumer accepts the presented instruction
//   proc2Imem_addr      out  fetch address (meaningful when imem_req=1)
//   imem_req            out  fetch issued this cycle
//   if_PC_out           out  PC of the presented instruction
//   if_NPC_out          out  if_PC_out + 4
//   if_IR_out           out  presented instruction word (NOOP_WORD when empty)
//   if_valid_inst_out   out  presented instruction is valid
module if_prefetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOOP_WORD = 32'h0000_0013
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] Imem2proc_data,
    input  logic        rf_take_branch_out,
    input  logic [31:0] rf_target_PC_out,
    input  logic        id_ready,
    output logic [31:0] proc2Imem_addr,
    output logic        imem_req,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_IR_out,
    output logic        if_valid_inst_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW:0]   OCC_MAX  = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic          r_inflight;
    logic [31:0]   r_tag;
    logic [31:0]   r_q_pc [DEPTH];
    logic [31:0]   r_q_ir [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_occ;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & id_ready & ~rf_take_branch_out;
    assign w_push  = r_inflight & ~rf_take_branch_out;

    // Occupancy after this cycle's pop, counting the word still in flight.
    // Issuing only while this is below DEPTH guarantees a free slot when the
    // word returns next cycle.
    assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    assign w_issue = HRESETn & ~rf_take_branch_out & (w_occ < OCC_MAX);

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (rf_take_branch_out) begin
            // Redirect wins over pop, capture and issue; the returning word
            // is dropped simply by not capturing it.
            r_fetch_pc <= {rf_target_PC_out[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tag      <= r_fetch_pc;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= r_count + (w_push ? CNT_ONE : '0) - (w_pop ? CNT_ONE : '0);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && w_push) begin
            r_q_pc[r_wr_ptr] <= r_tag;
            r_q_ir[r_wr_ptr] <= Imem2proc_data;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn && w_push) begin
            assert (r_count != CNT_FULL);
        end
    end

    assign proc2Imem_addr    = r_fetch_pc;
    assign imem_req          = w_issue;
    assign if_valid_inst_out = w_valid;
    assign if_PC_out         = w_valid ? r_q_pc[r_rd_ptr] : 32'd0;
    assign if_NPC_out        = w_valid ? (r_q_pc[r_rd_ptr] + 32'd4) : 32'd0;
    assign if_IR_out         = w_valid ? r_q_ir[r_rd_ptr] : NOOP_WORD;

endmodule
